// File: rtl/axis_pwm_audio_out.sv
// Stereo PWM audio output fed by an AXI-Stream of 2-word (left, right) packets.
// A shadow pair is filled from the stream and handed to the PWM comparators
// only at the counter wrap, so every PWM period uses a single stable duty.
`timescale 1ns/1ps
module axis_pwm_audio_out #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic                  pwm_l,
    output logic                  pwm_r,
    output logic                  underrun,
    output logic                  framing_err
);

    typedef enum logic [1:0] {
        WAIT_L = 2'd0,
        WAIT_R = 2'd1,
        FULL   = 2'd2
    } rx_state_t;

    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Two's complement to offset binary: flipping the MSB is exact for the full range.
    function automatic logic [DATA_WIDTH-1:0] to_offset(input logic [DATA_WIDTH-1:0] sample);
        return sample ^ MIDSCALE;
    endfunction

    rx_state_t             state_r, state_s;
    logic [DATA_WIDTH-1:0] pwm_cnt_r;
    logic [DATA_WIDTH-1:0] shadow_l_r, shadow_l_s;
    logic [DATA_WIDTH-1:0] shadow_r_r, shadow_r_s;
    logic [DATA_WIDTH-1:0] active_l_r, active_l_s;
    logic [DATA_WIDTH-1:0] active_r_r, active_r_s;
    logic                  pwm_l_r, pwm_r_r;
    logic                  underrun_r, underrun_s;
    logic                  framing_err_r, framing_err_s;
    logic                  wrap_s;
    logic                  xfer_s;

    // Ready comes straight from the registered state so it never depends on valid.
    assign s_axis_ready = (state_r != FULL);
    assign xfer_s       = s_axis_valid & s_axis_ready;
    assign wrap_s       = (pwm_cnt_r == ALL_ONES);

    assign pwm_l       = pwm_l_r;
    assign pwm_r       = pwm_r_r;
    assign underrun    = underrun_r;
    assign framing_err = framing_err_r;

    // Packet receive FSM, shadow capture and wrap-time hand-over to the comparators.
    always_comb begin
        state_s       = state_r;
        shadow_l_s    = shadow_l_r;
        shadow_r_s    = shadow_r_r;
        active_l_s    = active_l_r;
        active_r_s    = active_r_r;
        framing_err_s = 1'b0;
        underrun_s    = 1'b0;
        case (state_r)
            WAIT_L: begin
                if (xfer_s && !s_axis_last) begin
                    shadow_l_s = s_axis_data;
                    state_s    = WAIT_R;
                end else if (xfer_s) begin
                    // A right word with no left word before it is dropped.
                    framing_err_s = 1'b1;
                end else begin
                    state_s = WAIT_L;
                end
            end
            WAIT_R: begin
                if (xfer_s && s_axis_last) begin
                    shadow_r_s = s_axis_data;
                    state_s    = FULL;
                end else if (xfer_s) begin
                    // A second left word replaces the first; keep waiting for right.
                    shadow_l_s    = s_axis_data;
                    framing_err_s = 1'b1;
                end else begin
                    state_s = WAIT_R;
                end
            end
            FULL: begin
                if (wrap_s) begin
                    active_l_s = to_offset(shadow_l_r);
                    active_r_s = to_offset(shadow_r_r);
                    state_s    = WAIT_L;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = WAIT_L;
            end
        endcase
        // Decided on the pre-update state: a pair completing on the wrap is one period late.
        if (wrap_s && (state_r != FULL)) begin
            underrun_s = 1'b1;
        end else begin
            underrun_s = 1'b0;
        end
    end

    // State, counter, sample registers and registered PWM/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= WAIT_L;
            pwm_cnt_r     <= {DATA_WIDTH{1'b0}};
            shadow_l_r    <= {DATA_WIDTH{1'b0}};
            shadow_r_r    <= {DATA_WIDTH{1'b0}};
            active_l_r    <= MIDSCALE;
            active_r_r    <= MIDSCALE;
            pwm_l_r       <= 1'b0;
            pwm_r_r       <= 1'b0;
            underrun_r    <= 1'b0;
            framing_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pwm_cnt_r     <= pwm_cnt_r + ONE;
            shadow_l_r    <= shadow_l_s;
            shadow_r_r    <= shadow_r_s;
            active_l_r    <= active_l_s;
            active_r_r    <= active_r_s;
            // The comparison uses the active value in force for this counter value,
            // so a load at the wrap first applies at count 0.
            pwm_l_r       <= (pwm_cnt_r < active_l_r);
            pwm_r_r       <= (pwm_cnt_r < active_r_r);
            underrun_r    <= underrun_s;
            framing_err_r <= framing_err_s;
        end
    end

endmodule

// File: tb/tb_axis_pwm_audio_out.sv
// Scoreboard bench for axis_pwm_audio_out: the stimulus pushes the expected
// per-period duty/pulse counts, a monitor measures each PWM period and compares.
`timescale 1ns/1ps
module tb_axis_pwm_audio_out;

    localparam int DW  = 12;
    localparam int PER = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_last = 1'b0;
    logic          s_axis_ready;
    logic          pwm_l, pwm_r, underrun, framing_err;

    axis_pwm_audio_out #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .pwm_l        (pwm_l),
        .pwm_r        (pwm_r),
        .underrun     (underrun),
        .framing_err  (framing_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hl;
        int hr;
        int ur;
        int fe;
    } period_t;

    period_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int edge_n = 0;   // index of the next rising edge since reset release

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Count rising edges after reset release; the counter value at edge k is k mod PER.
    always @(posedge clk) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Monitor: sample after edge s reflects counter value s, so windows of PER samples are periods.
    initial begin
        int al, ar, au, af, upos, s, pos, per;
        period_t e;
        al = 0; ar = 0; au = 0; af = 0; upos = -1;
        forever begin
            @(negedge clk);
            if (!reset && edge_n > 0) begin
                s   = edge_n - 1;
                pos = s % PER;
                per = s / PER;
                if (pos == 0) begin
                    al = 0; ar = 0; au = 0; af = 0; upos = -1;
                end
                al += int'(pwm_l);
                ar += int'(pwm_r);
                af += int'(framing_err);
                if (underrun) begin
                    au++;
                    upos = pos;
                end
                if (pos == PER - 1) begin
                    if (sb_q.size() == 0) begin
                        check_eq($sformatf("p%0d_sb_empty", per), 0, 1);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq($sformatf("p%0d_high_l", per), al, e.hl);
                        check_eq($sformatf("p%0d_high_r", per), ar, e.hr);
                        check_eq($sformatf("p%0d_underruns", per), au, e.ur);
                        check_eq($sformatf("p%0d_framing", per), af, e.fe);
                        if (e.ur == 1) check_eq($sformatf("p%0d_ur_pos", per), upos, PER - 1);
                    end
                end
            end
        end
    end

    task automatic push_period(input int hl, input int hr, input int ur, input int fe);
        period_t p;
        p.hl = hl; p.hr = hr; p.ur = ur; p.fe = fe;
        sb_q.push_back(p);
    endtask

    // Driver phase is always #1 after a rising edge.
    task automatic wait_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word so that it is sampled at edge n.
    task automatic send(input logic [DW-1:0] d, input logic last, input int n);
        wait_edge(n);
        s_axis_data  = d;
        s_axis_last  = last;
        s_axis_valid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pwm_l", int'(pwm_l), 0);
        check_eq("rst_pwm_r", int'(pwm_r), 0);
        check_eq("rst_underrun", int'(underrun), 0);
        check_eq("rst_framing", int'(framing_err), 0);

        // Period 0: idle, midscale silence, one underrun.
        push_period(2048, 2048, 1, 0);
        reset = 1'b0;
        wait_edge(1);
        check_eq("ready_after_reset", int'(s_axis_ready), 1);

        // Period 1: left overwritten by a second left word, then a full pair.
        push_period(2048, 2048, 0, 1);
        send(12'h100, 1'b0, PER + 10);
        send(12'h7FF, 1'b0, PER + 12);
        send(12'h800, 1'b1, PER + 14);
        check_eq("full_ready_low", int'(s_axis_ready), 0);
        wait_edge(2 * PER - 1);
        check_eq("full_ready_hold", int'(s_axis_ready), 0);
        wait_edge(2 * PER);
        check_eq("ready_after_load", int'(s_axis_ready), 1);

        // Period 2: max/min duty; stray right word is a framing error.
        push_period(4095, 0, 1, 1);
        send(12'h123, 1'b1, 2 * PER + 20);
        check_eq("fe_pulse", int'(framing_err), 1);
        check_eq("fe_ready", int'(s_axis_ready), 1);
        @(posedge clk);
        #1;
        check_eq("fe_one_cycle", int'(framing_err), 0);

        // Period 3: right word accepted exactly on the wrap edge.
        push_period(4095, 0, 1, 0);
        send(12'h400, 1'b0, 3 * PER + 100);
        send(12'hC00, 1'b1, 4 * PER - 1);
        check_eq("wrap_ur_pulse", int'(underrun), 1);
        check_eq("wrap_ready_low", int'(s_axis_ready), 0);

        // Period 4: pair held in FULL, old duty still applies.
        push_period(4095, 0, 0, 0);
        wait_edge(5 * PER);
        check_eq("wrap_ready_after", int'(s_axis_ready), 1);

        // Period 5: +1024 -> 3072, -1024 -> 1024.
        push_period(3072, 1024, 1, 0);

        // Mid-packet reset discards the left word and restores midscale.
        send(12'h000, 1'b0, 6 * PER + 50);
        wait_edge(6 * PER + 60);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_pwm_l", int'(pwm_l), 0);
        check_eq("mid_rst_underrun", int'(underrun), 0);
        check_eq("mid_rst_framing", int'(framing_err), 0);
        check_eq("mid_rst_ready", int'(s_axis_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        push_period(2048, 2048, 1, 1);
        push_period(2048, 2048, 1, 0);
        reset = 1'b0;
        send(12'h7FF, 1'b1, 20);
        check_eq("post_rst_fe", int'(framing_err), 1);
        wait_edge(2 * PER + 5);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_pwm_audio_out.md
AXIS_PWM_AUDIO_OUT -- requirements
Module: axis_pwm_audio_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: sample width in bits, signed two's complement.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; the ports are named clk and reset.
REQ-003 SHALL have port clk  input  1: sole clock, all logic rising-edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port s_axis_data  input  DATA_WIDTH: signed sample word.
REQ-006 SHALL have port s_axis_valid  input  1: slave word valid.
REQ-007 SHALL have port s_axis_ready  output  1: slave ready.
REQ-008 SHALL have port s_axis_last  input  1: 0 = left word, 1 = right word (end of 2-word packet).
REQ-009 SHALL have port pwm_l  output  1: left-channel PWM, registered.
REQ-010 SHALL have port pwm_r  output  1: right-channel PWM, registered.
REQ-011 SHALL have port underrun  output  1: one-cycle pulse, no sample pair ready at period boundary.
REQ-012 SHALL have port framing_err  output  1: one-cycle pulse, packet structure violated.

Function
REQ-013 SHALL consume 2-word packets (left, then right with last=1); transfer occurs when valid and ready are both 1.
REQ-014 SHALL run a free-running counter pwm_cnt of DATA_WIDTH bits, 0 to 2^DATA_WIDTH-1, wrapping to 0; the wrap cycle is pwm_cnt = all-ones.
REQ-015 SHALL implement receive states WAIT_L, WAIT_R, FULL, with s_axis_ready = 1 in WAIT_L/WAIT_R and 0 in FULL, decoded from the registered state only.
REQ-016 SHALL, in WAIT_L: on a transfer with last=0, store the word in shadow_l and go to WAIT_R; on last=1, discard the word, pulse framing_err and stay in WAIT_L.
REQ-017 SHALL, in WAIT_R: on a transfer with last=1, store shadow_r and go to FULL; on last=0, overwrite shadow_l, pulse framing_err and stay in WAIT_R.
REQ-018 SHALL, on the wrap cycle with state = FULL (state before update): load active_l/active_r from the shadows converted to offset binary (invert MSB) and go to WAIT_L.
REQ-019 SHALL, on the wrap cycle with state not FULL: hold active_l/active_r and pulse underrun for exactly one cycle.
REQ-020 SHALL use the pre-update state when a packet completes on the wrap cycle: pulse underrun, enter FULL, and load at the next wrap.
REQ-021 SHALL register pwm_x <= (pwm_cnt < active_x); mapping: code 0 (offset) gives constant low, all-ones gives high for 2^DATA_WIDTH-1 of 2^DATA_WIDTH cycles.
REQ-022 SHALL apply a newly loaded active value starting at compare pwm_cnt = 0, visible on pwm_x one cycle later, so loads never produce glitched periods.
REQ-023 SHALL keep conversion exact: -2^(DATA_WIDTH-1) maps to 0, 0 maps to 2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1 maps to all-ones; no saturation is needed.
REQ-024 SHALL never drop an accepted right word: FULL blocks input until consumed.

Reset
REQ-025 SHALL, while reset = 1, force: pwm_cnt = 0, state = WAIT_L, shadow_l = shadow_r = 0, active_l = active_r = 2^(DATA_WIDTH-1) (midscale silence), pwm_l = pwm_r = 0, underrun = framing_err = 0.
REQ-026 SHALL, on reset asserted mid-packet, discard any partial packet and pending FULL pair, with no underrun/framing_err pulse caused by the reset.
REQ-027 SHALL leave s_axis_ready = 1 from the first clock after reset release.

Verification
REQ-028 SHALL pass: reset then idle -> ready = 1; pwm_l/pwm_r high 2048 of every 4096 cycles; underrun pulses once per 4096 cycles.
REQ-029 SHALL pass: packet L = 0x7FF, R = 0x800 -> ready = 0 after R accepted until the wrap; from the next period pwm_l is high 4095/4096 and pwm_r is constantly low.
REQ-030 SHALL pass: first word with last = 1 (0x123) -> framing_err pulses 1 cycle, state stays WAIT_L, duty unchanged.
REQ-031 SHALL pass: R accepted exactly on the pwm_cnt = 4095 cycle -> underrun pulses, ready = 0, new duty takes effect one period later.
REQ-032 SHALL pass: L = 0x000 accepted, reset pulsed, then R sent with last = 1 -> framing_err pulses, no load, duty stays 2048.
